// File: rtl/port_display_pkg.sv
// -----------------------------------------------------------------------------
// port_display_pkg
// Shared definitions for the KCPSM6 port-bus seven-segment display block:
// register offsets inside the 16-byte window, CTRL field layout, reset values
// and the hex-to-segment lookup table (active-high, bit order {g,f,e,d,c,b,a}).
// -----------------------------------------------------------------------------
package port_display_pkg;

  // Register offsets inside the window (port_id[3:0]).
  typedef enum logic [3:0] {
    OFF_DIGIT0 = 4'h0,
    OFF_DIGIT1 = 4'h1,
    OFF_DIGIT2 = 4'h2,
    OFF_DIGIT3 = 4'h3,
    OFF_DIGIT4 = 4'h4,
    OFF_DIGIT5 = 4'h5,
    OFF_DIGIT6 = 4'h6,
    OFF_DIGIT7 = 4'h7,
    OFF_MASK   = 4'h8,
    OFF_CTRL   = 4'h9,
    OFF_STATUS = 4'hA
  } reg_off_e;

  // CTRL bit positions in the firmware-visible byte.
  localparam int CTRL_SCAN_EN_BIT = 0;
  localparam int CTRL_RAW_BIT     = 1;

  // DIGITn field positions.
  localparam int DIGIT_DP_BIT    = 4;
  localparam int DIGIT_BLANK_BIT = 7;

  // STATUS field positions.
  localparam int STATUS_WRAP_BIT = 7;

  // Stored CTRL bits; packed so that {6'b0, ctrl} reproduces the CTRL byte.
  typedef struct packed {
    logic raw;
    logic scan_en;
  } ctrl_t;

  // Reset values.
  localparam logic [7:0] DIGIT_RESET = 8'h80;
  localparam logic [7:0] MASK_RESET  = 8'hFF;
  localparam ctrl_t      CTRL_RESET  = '{raw: 1'b0, scan_en: 1'b1};
  localparam logic [7:0] AN_OFF      = 8'hFF;
  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [7:0] RD_RESET    = 8'h00;

  // Hex-to-segment table, active-high {g..a}; element [0] is digit 0.
  localparam logic [15:0][6:0] HEX7SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

endpackage : port_display_pkg

// File: rtl/port_display_ctrl_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Purely combinational hex nibble to seven-segment decoder (active-high).
// Ports:
//   hex_i  [3:0]  hex value to display
//   seg_o  [6:0]  segments {g,f,e,d,c,b,a}, 1 = lit
// -----------------------------------------------------------------------------
module seg7_decode
  import port_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7SEG_TABLE[hex_i];

endmodule : seg7_decode

// File: rtl/port_display_ctrl.sv
// -----------------------------------------------------------------------------
// port_display_ctrl
// KCPSM6 port-bus responder owning an 8-digit multiplexed seven-segment
// display. Firmware writes DIGIT0..7 / MASK / CTRL with OUTPUT and reads all
// registers plus STATUS back with INPUT via the registered rd_data mux.
// An internal refresh counter steps the digit index every REFRESH_DIV clocks.
// Ports:
//   clk           system clock (shared with the processor)
//   reset_n       asynchronous active-low reset
//   port_id[7:0]  processor port address; window is BASE_ADDR[7:4]
//   out_port[7:0] processor write data
//   write_strobe  one-cycle write qualifier
//   read_strobe   read qualifier; reads have no dependence on it
//   rd_data[7:0]  registered read data towards the in_port mux
//   an[7:0]       digit anodes, active-low
//   seg[7:0]      segments, active-low {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module port_display_ctrl
  import port_display_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'h10,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] rd_data,
  output logic [7:0] an,
  output logic [7:0] seg
);

  localparam int unsigned      CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Address decode
  logic       hit_s;
  logic [3:0] offset_s;
  logic       wr_hit_s;
  logic       status_rd_s;

  // Register file
  logic [7:0] digit_q [8];
  logic [7:0] digit_d [8];
  logic [7:0] mask_q;
  logic [7:0] mask_d;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_d;

  // Scan state
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       idx_q;
  logic [2:0]       idx_d;
  logic             adv_s;
  logic             wrap_s;
  logic             wrap_q;
  logic             wrap_d;

  // Display and read path
  logic [7:0] cur_digit_s;
  logic [6:0] hex_seg_s;
  logic       digit_on_s;
  logic [7:0] an_d;
  logic [7:0] an_q;
  logic [7:0] seg_d;
  logic [7:0] seg_q;
  logic [7:0] rd_d;
  logic [7:0] rd_q;

  // read_strobe carries no side effects; reads are purely address driven.
  logic unused_s;
  assign unused_s = read_strobe;

  assign hit_s       = (port_id[7:4] == BASE_ADDR[7:4]);
  assign offset_s    = port_id[3:0];
  assign wr_hit_s    = write_strobe && hit_s;
  // Any cycle that presents the STATUS address counts as a read of it.
  assign status_rd_s = hit_s && (offset_s == OFF_STATUS);

  assign cur_digit_s = digit_q[idx_q];

  seg7_decode u_seg7_decode (
    .hex_i (cur_digit_s[3:0]),
    .seg_o (hex_seg_s)
  );

  // Register-file next state from processor writes.
  always_comb begin
    digit_d = digit_q;
    mask_d  = mask_q;
    ctrl_d  = ctrl_q;
    if (wr_hit_s) begin
      if (offset_s[3] == 1'b0) begin
        digit_d[offset_s[2:0]] = out_port;
      end else begin
        case (offset_s)
          OFF_MASK: mask_d = out_port;
          OFF_CTRL: begin
            ctrl_d.scan_en = out_port[CTRL_SCAN_EN_BIT];
            ctrl_d.raw     = out_port[CTRL_RAW_BIT];
          end
          // STATUS is read-only; B..F are unmapped.
          default: mask_d = mask_q;
        endcase
      end
    end else begin
      mask_d = mask_q;
    end
  end

  // Register-file state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        digit_q[i] <= DIGIT_RESET;
      end
      mask_q <= MASK_RESET;
      ctrl_q <= CTRL_RESET;
    end else begin
      digit_q <= digit_d;
      mask_q  <= mask_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Refresh counter and digit index; both hold while scanning is disabled.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    adv_s = 1'b0;
    if (ctrl_q.scan_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = idx_q + 3'd1;
        adv_s = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      adv_s = 1'b0;
    end
  end

  assign wrap_s = adv_s && (idx_q == 3'd7);

  // STATUS wrap flag lives for one slot; a wrap beats a same-cycle read clear.
  always_comb begin
    wrap_d = wrap_q;
    if (wrap_s) begin
      wrap_d = 1'b1;
    end else if (status_rd_s || adv_s) begin
      wrap_d = 1'b0;
    end else begin
      wrap_d = wrap_q;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  // A blank digit stays dark in decoded mode but raw mode owns all eight bits.
  assign digit_on_s = ctrl_q.scan_en && mask_q[idx_q] &&
                      (ctrl_q.raw || !cur_digit_s[DIGIT_BLANK_BIT]);

  // Anode/segment drive for the current slot.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (digit_on_s) begin
      an_d = ~(8'h01 << idx_q);
      if (ctrl_q.raw) begin
        seg_d = ~cur_digit_s;
      end else begin
        seg_d = ~{cur_digit_s[DIGIT_DP_BIT], hex_seg_s};
      end
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
  end

  // Read mux, evaluated every cycle from port_id.
  always_comb begin
    rd_d = RD_RESET;
    if (hit_s) begin
      case (offset_s)
        OFF_DIGIT0, OFF_DIGIT1, OFF_DIGIT2, OFF_DIGIT3,
        OFF_DIGIT4, OFF_DIGIT5, OFF_DIGIT6, OFF_DIGIT7:
                    rd_d = digit_q[offset_s[2:0]];
        OFF_MASK:   rd_d = mask_q;
        OFF_CTRL:   rd_d = {6'b000000, ctrl_q};
        OFF_STATUS: rd_d = {wrap_q, 4'b0000, idx_q};
        default:    rd_d = RD_RESET;
      endcase
    end else begin
      rd_d = RD_RESET;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      rd_q  <= RD_RESET;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      rd_q  <= rd_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign rd_data = rd_q;

endmodule : port_display_ctrl

// File: tb/tb_port_display_ctrl.sv
// Scoreboard bench for port_display_ctrl with BASE_ADDR = 8'h10, REFRESH_DIV = 4.
module tb_port_display_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] rd_data;
  logic [7:0] an;
  logic [7:0] seg;

  port_display_ctrl #(
    .BASE_ADDR   (8'h10),
    .REFRESH_DIV (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .rd_data      (rd_data),
    .an           (an),
    .seg          (seg)
  );

  localparam int SEL_RD  = 0;
  localparam int SEL_AN  = 1;
  localparam int SEL_SEG = 2;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] exp;
    logic [7:0] msk;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_total;
  int   n_pass;

  // Slot position tracker: 4 clocks per slot, 8 slots, frozen when CTRL[0]=0.
  logic [1:0] m_cnt;
  logic [2:0] m_idx;
  logic       m_scan;

  // Hand-computed walk with DIGITn = n except DIGIT0 = 3.
  logic [7:0] walk_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] walk_seg [8] = '{8'hB0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= 2'd0;
      m_idx  <= 3'd0;
      m_scan <= 1'b1;
    end else begin
      if (write_strobe && port_id == 8'h19) m_scan <= out_port[0];
      if (m_scan) begin
        if (m_cnt == 2'd3) begin
          m_cnt <= 2'd0;
          m_idx <= m_idx + 3'd1;
        end else begin
          m_cnt <= m_cnt + 2'd1;
        end
      end
    end
  end

  // Monitor: compares every expectation that has come due, at the falling edge.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        case (e.sel)
          SEL_RD:  act = rd_data;
          SEL_AN:  act = an;
          default: act = seg;
        endcase
        n_total++;
        if ((act & e.msk) == e.exp) n_pass++;
        else $display("FAIL %s: got %02h, expected %02h (mask %02h) at cycle %0d",
                      e.name, act & e.msk, e.exp, e.msk, cyc);
      end
    end
  end

  task automatic push(input int due, input int sel, input logic [7:0] e,
                      input logic [7:0] m, input string n);
    exp_t x;
    x.due = due; x.sel = sel; x.exp = e; x.msk = m; x.name = n;
    sb.push_back(x);
  endtask

  task automatic expect_disp(input logic [7:0] a, input logic [7:0] s, input string n);
    push(cyc + 1, SEL_AN,  a, 8'hFF, {n, "_an"});
    push(cyc + 1, SEL_SEG, s, 8'hFF, {n, "_seg"});
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id      = a;
    out_port     = d;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic rd_check(input logic [7:0] a, input logic [7:0] e,
                          input logic [7:0] m, input string n);
    port_id = a;
    push(cyc + 1, SEL_RD, e, m, n);
    @(negedge clk);
  endtask

  // Returns at the falling edge just after the index stepped to n.
  task automatic wait_idx(input logic [2:0] n, input string nm);
    int b;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!(m_idx == n && m_cnt == 2'd0) && b < 200);
    if (!(m_idx == n && m_cnt == 2'd0)) begin
      n_total++;
      $display("FAIL %s: timeout, index %0d not reached, got %0d", nm, n, m_idx);
    end
  endtask

  initial begin
    int b;
    n_total      = 0;
    n_pass       = 0;
    reset_n      = 1'b0;
    port_id      = 8'h00;
    out_port     = 8'h00;
    write_strobe = 1'b0;
    read_strobe  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    expect_disp(8'hFF, 8'hFF, "rst");
    push(cyc + 1, SEL_RD, 8'h00, 8'hFF, "rst_rd");
    @(negedge clk);
    reset_n = 1'b1;
    rd_check(8'h19, 8'h01, 8'hFF, "ctrl_rst");
    rd_check(8'h18, 8'hFF, 8'hFF, "mask_rst");
    rd_check(8'h10, 8'h80, 8'hFF, "digit0_rst");

    // Digit walk
    wr(8'h10, 8'h03);
    for (int n = 1; n < 8; n++) wr(8'h10 + 8'(n), 8'(n));
    wait_idx(3'd0, "walk0");
    expect_disp(8'hFE, 8'hB0, "walk0");
    for (int n = 1; n < 8; n++) begin
      wait_idx(3'(n), $sformatf("walk%0d", n));
      expect_disp(walk_an[n], walk_seg[n], $sformatf("walk%0d", n));
    end
    wait_idx(3'd0, "wrap");
    expect_disp(walk_an[0], walk_seg[0], "wrap");
    rd_check(8'h1A, 8'h80, 8'hFF, "status_wrap");
    rd_check(8'h1A, 8'h00, 8'hFF, "status_clr");

    // Decimal point and readback
    wr(8'h12, 8'h15);
    rd_check(8'h12, 8'h15, 8'hFF, "digit2_rd");
    wait_idx(3'd2, "dp2");
    expect_disp(8'hFB, 8'h12, "dp2");

    // Mask and freeze
    wr(8'h18, 8'hFB);
    wait_idx(3'd2, "masked2");
    expect_disp(8'hFF, 8'hFF, "masked2");
    wait_idx(3'd3, "slot3");
    expect_disp(8'hF7, 8'hB0, "slot3");
    wait_idx(3'd4, "pre_freeze");
    wr(8'h19, 8'h00);
    expect_disp(8'hFF, 8'hFF, "frozen");
    rd_check(8'h1A, 8'h04, 8'hFF, "frozen_idx");
    repeat (10) @(negedge clk);
    expect_disp(8'hFF, 8'hFF, "frozen_late");
    rd_check(8'h1A, 8'h04, 8'hFF, "frozen_idx_late");
    wr(8'h19, 8'h01);
    expect_disp(8'hEF, 8'h99, "resume4");
    wait_idx(3'd5, "resume5");
    expect_disp(8'hDF, 8'h92, "resume5");

    // Raw mode
    wr(8'h19, 8'h03);
    wr(8'h15, 8'hA5);
    wait_idx(3'd5, "raw5");
    expect_disp(8'hDF, 8'h5A, "raw5");
    wait_idx(3'd6, "raw6");
    expect_disp(8'hBF, 8'hF9, "raw6");
    wr(8'h19, 8'hFD);
    rd_check(8'h19, 8'h01, 8'hFF, "ctrl_rsvd");
    rd_check(8'h15, 8'hA5, 8'hFF, "digit5_rd");
    wait_idx(3'd5, "blank5");
    expect_disp(8'hFF, 8'hFF, "blank5");

    // Unmapped and out-of-window accesses
    rd_check(8'h1C, 8'h00, 8'hFF, "off_c");
    rd_check(8'h1F, 8'h00, 8'hFF, "off_f");
    rd_check(8'h20, 8'h00, 8'hFF, "port20");
    wr(8'h20, 8'h55);
    rd_check(8'h10, 8'h03, 8'hFF, "outside_wr");
    wr(8'h1A, 8'h7F);
    rd_check(8'h1A, 8'h00, 8'h78, "status_ro");

    // Asynchronous reset mid-slot
    port_id = 8'h19;
    wait_idx(3'd0, "pre_reset");
    expect_disp(8'hFE, 8'hB0, "pre_reset");
    @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    push(cyc, SEL_AN,  8'hFF, 8'hFF, "async_an");
    push(cyc, SEL_SEG, 8'hFF, 8'hFF, "async_seg");
    push(cyc, SEL_RD,  8'h00, 8'hFF, "async_rd");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    port_id = 8'h1A;
    for (int k = 1; k <= 4; k++) push(cyc + k, SEL_RD, 8'h00, 8'hFF, $sformatf("slot_len%0d", k));
    push(cyc + 5, SEL_RD, 8'h01, 8'hFF, "slot_len5");
    repeat (5) @(negedge clk);
    rd_check(8'h10, 8'h80, 8'hFF, "digit0_rst2");
    rd_check(8'h18, 8'hFF, 8'hFF, "mask_rst2");
    rd_check(8'h19, 8'h01, 8'hFF, "ctrl_rst2");

    // Drain the scoreboard
    b = 0;
    while (sb.size() > 0 && b < 20) begin
      @(negedge clk);
      b++;
    end
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      n_total++;
      $display("FAIL %s: never compared, expected %02h", x.name, x.exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, got %0d checks, expected completion", n_total);
    $fatal(1, "watchdog");
  end

endmodule : tb_port_display_ctrl
